// File: rtl/prim_ram_1p_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prim_ram_1p_arb_if : requester-side and RAM-side bus of the 1-port RAM arbiter
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface prim_ram_1p_arb_if #(
    parameter int Width = 32,
    parameter int Depth = 2048
);
    localparam int Aw = $clog2(Depth);

    logic [1:0]         req_i;
    logic [1:0]         gnt_o;
    logic [1:0]         write_i;
    logic [2*Aw-1:0]    addr_i;
    logic [2*Width-1:0] wdata_i;
    logic [2*Width-1:0] wmask_i;
    logic [1:0]         rvalid_o;
    logic [Width-1:0]   rdata_o;
`ifdef PRIM_RAM_1P_ARB_ADDR_CHECK_EN
    logic [1:0]         err_o;
`endif
    logic               ram_req_o;
    logic               ram_write_o;
    logic [Aw-1:0]      ram_addr_o;
    logic [Width-1:0]   ram_wdata_o;
    logic [Width-1:0]   ram_wmask_o;
    logic               ram_rvalid_i;
    logic [Width-1:0]   ram_rdata_i;

    modport slave (
        input  req_i, write_i, addr_i, wdata_i, wmask_i, ram_rvalid_i, ram_rdata_i,
        output gnt_o, rvalid_o, rdata_o,
`ifdef PRIM_RAM_1P_ARB_ADDR_CHECK_EN
        output err_o,
`endif
        output ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o
    );

    modport master (
        output req_i, write_i, addr_i, wdata_i, wmask_i, ram_rvalid_i, ram_rdata_i,
        input  gnt_o, rvalid_o, rdata_o,
`ifdef PRIM_RAM_1P_ARB_ADDR_CHECK_EN
        input  err_o,
`endif
        input  ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o
    );
endinterface
`default_nettype wire

// File: rtl/prim_ram_1p_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prim_ram_1p_arb : round-robin two-requester arbiter in front of a 1-port RAM
// Optional macro PRIM_RAM_1P_ARB_ADDR_CHECK_EN adds out-of-range checking (err_o).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module prim_ram_1p_arb #(
    parameter int Width           = 32,
    parameter int Depth           = 2048,
    parameter int DataBitsPerMask = 8
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    prim_ram_1p_arb_if.slave     bus
);
    localparam int Aw = $clog2(Depth);

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_idx_e;

    // Mask granularity belongs to the RAM; only its consistency is checked here.
    if (DataBitsPerMask < 1 || (Width % DataBitsPerMask) != 0) begin : g_bad_mask_cfg
        $error("prim_ram_1p_arb: Width must be a multiple of DataBitsPerMask");
    end

    req_idx_e         r_prio_q;
    req_idx_e         r_owner_q;
    logic             r_pend_q;

    logic [1:0]       w_gnt;
    logic             w_any;
    logic             w_sel;
    logic             w_write;
    logic [Aw-1:0]    w_addr;
    logic [Width-1:0] w_wdata;
    logic [Width-1:0] w_wmask;
    logic             w_ram_req;
    logic             w_rd_issue;
    logic [1:0]       w_own;

    // Grant is gated by reset so nothing leaks out while rst_i is high.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst_i) begin
            if (bus.req_i == 2'b11) begin
                w_gnt = (r_prio_q == REQ_B) ? 2'b10 : 2'b01;
            end else begin
                w_gnt = bus.req_i;
            end
        end
    end

    assign w_any = |w_gnt;
    assign w_sel = w_gnt[1];

    always_comb begin
        w_write = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_wmask = '0;
        if (w_any) begin
            w_write = bus.write_i[w_sel];
            w_addr  = w_sel ? bus.addr_i[2*Aw-1:Aw]          : bus.addr_i[Aw-1:0];
            w_wdata = w_sel ? bus.wdata_i[2*Width-1:Width]   : bus.wdata_i[Width-1:0];
            w_wmask = w_sel ? bus.wmask_i[2*Width-1:Width]   : bus.wmask_i[Width-1:0];
        end
    end

    assign w_rd_issue = w_any & ~w_write;
    assign w_own      = {r_owner_q == REQ_B, r_owner_q == REQ_A};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prio_q  <= REQ_A;
            r_owner_q <= REQ_A;
            r_pend_q  <= 1'b0;
        end else begin
            r_pend_q <= w_rd_issue;
            if (w_rd_issue) begin
                r_owner_q <= req_idx_e'(w_sel);
            end
            // Priority only moves on contention, to the loser of this cycle.
            if (bus.req_i == 2'b11) begin
                r_prio_q <= w_sel ? REQ_A : REQ_B;
            end
        end
    end

`ifdef PRIM_RAM_1P_ARB_ADDR_CHECK_EN
    logic       w_oob;
    logic       r_oob_q;
    logic [1:0] r_err_q;

    assign w_oob     = w_any && ({1'b0, w_addr} >= (Aw+1)'(Depth));
    assign w_ram_req = w_any & ~w_oob;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_oob_q <= 1'b0;
            r_err_q <= 2'b00;
        end else begin
            r_oob_q <= w_oob & ~w_write;
            r_err_q <= w_oob ? w_gnt : 2'b00;
        end
    end

    // An out-of-range read never reaches the RAM, so it completes locally with zero data.
    assign bus.rvalid_o = (r_pend_q & (r_oob_q | bus.ram_rvalid_i)) ? w_own : 2'b00;
    assign bus.rdata_o  = r_oob_q ? '0 : bus.ram_rdata_i;
    assign bus.err_o    = r_err_q;
`else
    assign w_ram_req    = w_any;
    assign bus.rvalid_o = (r_pend_q & bus.ram_rvalid_i) ? w_own : 2'b00;
    assign bus.rdata_o  = bus.ram_rdata_i;
`endif

    assign bus.gnt_o       = w_gnt;
    assign bus.ram_req_o   = w_ram_req;
    assign bus.ram_write_o = w_write;
    assign bus.ram_addr_o  = w_addr;
    assign bus.ram_wdata_o = w_wdata;
    assign bus.ram_wmask_o = w_wmask;

endmodule
`default_nettype wire

// File: tb/tb_prim_ram_1p_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_prim_ram_1p_arb : randomized bench with a transaction-level arbiter/RAM model
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_prim_ram_1p_arb;
    localparam int W = 32;
`ifdef PRIM_RAM_1P_ARB_ADDR_CHECK_EN
    localparam int DEPTH = 1000;
`else
    localparam int DEPTH = 2048;
`endif
    localparam int AW = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prim_ram_1p_arb_if #(.Width(W), .Depth(DEPTH)) bus ();

    prim_ram_1p_arb #(.Width(W), .Depth(DEPTH), .DataBitsPerMask(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Attached single-port RAM: one-cycle read latency, masked writes, no reset.
    logic [W-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        bus.ram_rvalid_i <= bus.ram_req_o & ~bus.ram_write_o;
        if (bus.ram_req_o) begin
            if (bus.ram_write_o)
                mem[bus.ram_addr_o] <= (mem[bus.ram_addr_o] & ~bus.ram_wmask_o) |
                                       (bus.ram_wdata_o & bus.ram_wmask_o);
            else
                bus.ram_rdata_i <= mem[bus.ram_addr_o];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: who wins, what the next response must be, and the memory image.
    int           m_prio;
    int           m_pend;
    int           m_owner;
    logic [W-1:0] m_data;
    logic [1:0]   m_err;
    logic [W-1:0] shadow [0:(1<<AW)-1];
    logic [W-1:0] last_rdata;
    logic [AW-1:0] atab [$];

    task automatic model_reset();
        m_prio  = 0;
        m_pend  = 0;
        m_owner = 0;
        m_err   = 2'b00;
        m_data  = '0;
    endtask

    // Drives one cycle's requests (entered at posedge+1), checks at negedge, returns at posedge+1.
    task automatic cyc(input logic [1:0] req, input logic [1:0] wr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] k0, input logic [W-1:0] k1);
        logic [1:0]    eg;
        int            s;
        logic [AW-1:0] ea;
        logic          ew;
        logic [W-1:0]  ed, em;
        logic          oob;
        bus.req_i   = req;
        bus.write_i = wr;
        bus.addr_i  = {a1, a0};
        bus.wdata_i = {d1, d0};
        bus.wmask_i = {k1, k0};
        @(negedge clk);
        if (req == 2'b11) eg = (m_prio == 1) ? 2'b10 : 2'b01;
        else              eg = req;
        s   = eg[1] ? 1 : 0;
        ea  = (s == 1) ? a1 : a0;
        ew  = wr[s];
        ed  = (s == 1) ? d1 : d0;
        em  = (s == 1) ? k1 : k0;
        oob = (eg != 2'b00) && (int'(ea) >= DEPTH);
        check_eq("gnt", bus.gnt_o, eg);
        check_eq("ram_req", bus.ram_req_o, (eg != 2'b00) && !oob);
        if (eg != 2'b00)
            check_eq("ram_cmd", {bus.ram_write_o, bus.ram_addr_o, bus.ram_wdata_o, bus.ram_wmask_o},
                     {ew, ea, ed, em});
        else
            check_eq("ram_cmd_idle", {bus.ram_write_o, bus.ram_addr_o, bus.ram_wdata_o, bus.ram_wmask_o},
                     '0);
        check_eq("rvalid", bus.rvalid_o, (m_pend == 1) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00);
        if (m_pend == 1) begin
            check_eq("rdata", bus.rdata_o, m_data);
            last_rdata = bus.rdata_o;
        end
`ifdef PRIM_RAM_1P_ARB_ADDR_CHECK_EN
        check_eq("err", bus.err_o, m_err);
`endif
        m_pend = 0;
        m_err  = 2'b00;
        if (eg != 2'b00) begin
            if (ew) begin
                if (!oob) shadow[ea] = (shadow[ea] & ~em) | (ed & em);
            end else begin
                m_pend  = 1;
                m_owner = s;
                m_data  = oob ? '0 : shadow[ea];
            end
            if (oob) m_err = eg;
        end
        if (req == 2'b11) m_prio = (s == 0) ? 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
    endtask

    localparam logic [W-1:0] FULL = '1;

    initial begin
        model_reset();
        last_rdata = '0;
        bus.req_i   = 2'b11;
        bus.write_i = 2'b00;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        bus.wmask_i = '0;
        @(negedge clk);
        check_eq("rst_gnt", bus.gnt_o, 2'b00);
        check_eq("rst_ram_req", bus.ram_req_o, 1'b0);
        check_eq("rst_rvalid", bus.rvalid_o, 2'b00);
`ifdef PRIM_RAM_1P_ARB_ADDR_CHECK_EN
        check_eq("rst_err", bus.err_o, 2'b00);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 32; i++) atab.push_back(AW'(i));
        atab.push_back(AW'(DEPTH - 1));
        atab.push_back(AW'(DEPTH - 2));

        // Preload every address the bench will ever read, alternating writers.
        for (int i = 0; i < atab.size(); i++) begin
            if (i % 2 == 0)
                cyc(2'b01, 2'b01, atab[i], '0, 32'hC0DE_0000 | W'(atab[i]), '0, FULL, '0);
            else
                cyc(2'b10, 2'b10, '0, atab[i], '0, 32'hC0DE_0000 | W'(atab[i]), '0, FULL);
        end
        idle();

        // Lone read by A.
        cyc(2'b01, 2'b00, AW'(16), '0, '0, '0, '0, '0);
        idle();

        // Four contended cycles: A, B, A, B.
        for (int i = 0; i < 4; i++)
            cyc(2'b11, 2'b00, AW'(i), AW'(i + 8), '0, '0, '0, '0);
        idle();

        // Partial write by B, read back by A.
        cyc(2'b10, 2'b10, '0, AW'(5), '0, 32'hDEAD_BEEF, '0, 32'h0000_FFFF);
        cyc(2'b01, 2'b00, AW'(5), '0, '0, '0, '0, '0);
        idle();
        check_eq("partial_write_rdata", last_rdata, 32'hC0DE_BEEF);

        // Lone B requests must not move priority; A wins next contention.
        for (int i = 0; i < 3; i++)
            cyc(2'b10, 2'b00, '0, AW'(i + 20), '0, '0, '0, '0);
        cyc(2'b11, 2'b00, AW'(1), AW'(2), '0, '0, '0, '0);
        idle();

        // Reset pulsed in the response cycle of a granted read.
        if (m_prio == 0) cyc(2'b11, 2'b00, AW'(3), AW'(4), '0, '0, '0, '0);
        idle();
        cyc(2'b01, 2'b00, AW'(16), '0, '0, '0, '0, '0);
        rst = 1'b1;
        #1;
        check_eq("rst_pulse_gnt", bus.gnt_o, 2'b00);
        check_eq("rst_pulse_rvalid", bus.rvalid_o, 2'b00);
        rst = 1'b0;
        model_reset();
        idle();
        cyc(2'b11, 2'b00, AW'(6), AW'(7), '0, '0, '0, '0);
        idle();

`ifdef PRIM_RAM_1P_ARB_ADDR_CHECK_EN
        cyc(2'b01, 2'b00, AW'(1020), '0, '0, '0, '0, '0);
        idle();
        cyc(2'b10, 2'b10, '0, AW'(1010), '0, 32'h1234_5678, '0, FULL);
        idle();
        atab.push_back(AW'(1020));
        atab.push_back(AW'(1001));
`endif

        for (int n = 0; n < 400; n++) begin
            logic [1:0]    rq, wr;
            logic [AW-1:0] a0, a1;
            logic [W-1:0]  k0, k1;
            rq = 2'($urandom_range(0, 3));
            wr = 2'($urandom_range(0, 3));
            a0 = atab[$urandom_range(0, atab.size() - 1)];
            a1 = atab[$urandom_range(0, atab.size() - 1)];
            k0 = ($urandom_range(0, 1) == 0) ? FULL : W'($urandom);
            k1 = ($urandom_range(0, 1) == 0) ? FULL : W'($urandom);
            cyc(rq, wr, a0, a1, W'($urandom), W'($urandom), k0, k1);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
